// File: rtl/sigmoid_pipe.sv
// sigmoid_pipe: 3-stage pipelined fixed-point logistic sigmoid (quadratic approximation)
// with valid/ready flow control and a pass-through sideband tag.
// Optional feature macro: SIGMOID_TANH_EN adds in_mode (1 = tanh via 2*sigmoid(2x) - 1).
module sigmoid_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
`ifdef SIGMOID_TANH_EN
  input  logic              in_mode,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned T_W = FRAC_W + 1;
  localparam int unsigned A_W = FRAC_W + 2;
  localparam int unsigned P_W = 2 * FRAC_W + 2;

  localparam logic [DATA_W-1:0]        FOUR_U   = {{(DATA_W-1){1'b0}}, 1'b1} << (FRAC_W + 2);
  localparam logic signed [DATA_W-1:0] FOUR_S   = $signed(FOUR_U);
  localparam logic signed [DATA_W-1:0] NFOUR_S  = $signed(~FOUR_U + {{(DATA_W-1){1'b0}}, 1'b1});
  localparam logic [T_W-1:0]           ONE_T    = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [DATA_W-1:0]        ONE_D    = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;
`ifdef SIGMOID_TANH_EN
  localparam logic [DATA_W-1:0]        MAX_D    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]        MIN_D    = {1'b1, {(DATA_W-1){1'b0}}};
`endif

  logic en;

  // stage 1 registers
  logic             s1_valid;
  logic             s1_sign;
  logic             s1_sat;
  logic [T_W-1:0]   s1_t;
  logic [TAG_W-1:0] s1_tag;
  // stage 2 registers
  logic             s2_valid;
  logic             s2_sign;
  logic             s2_sat;
  logic [P_W-1:0]   s2_p;
  logic [TAG_W-1:0] s2_tag;
`ifdef SIGMOID_TANH_EN
  logic             s1_mode;
  logic             s2_mode;
`endif

  // stage 1 combinational
  logic signed [DATA_W-1:0] x_c;
  logic                     sat_c;
  logic [A_W-1:0]           a_c;
  logic [T_W-1:0]           t_c;
  // stage 3 combinational
  logic [T_W-1:0]           h_c;
  logic [T_W-1:0]           y_c;
  logic [DATA_W-1:0]        res_c;

  // Whole pipeline advances together whenever the output slot is free or draining.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage 1: optional doubling, saturation classify, t = ONE - |x|/4.
  always_comb begin
    x_c = $signed(in_data);
`ifdef SIGMOID_TANH_EN
    if (in_mode) begin
      if (in_data[DATA_W-1] != in_data[DATA_W-2]) begin
        x_c = in_data[DATA_W-1] ? $signed(MIN_D) : $signed(MAX_D);
      end else begin
        x_c = $signed(in_data << 1);
      end
    end
`endif
    sat_c = (x_c >= FOUR_S) || (x_c <= NFOUR_S);
    // Low bits of the negation equal |x| whenever |x| < FOUR, so no full-width abs is needed.
    a_c   = x_c[DATA_W-1] ? (~x_c[A_W-1:0] + A_W'(1)) : x_c[A_W-1:0];
    t_c   = ONE_T - T_W'(a_c >> 2);
  end

  // Stage 3: halve the square and fold by sign; tanh rescales to 2y - ONE.
  always_comb begin
    h_c = T_W'(s2_p >> (FRAC_W + 1));
    if (s2_sat) begin
      y_c = s2_sign ? '0 : ONE_T;
    end else if (s2_sign) begin
      y_c = h_c;
    end else begin
      y_c = ONE_T - h_c;
    end
    res_c = DATA_W'(y_c);
`ifdef SIGMOID_TANH_EN
    if (s2_mode) begin
      res_c = (DATA_W'(y_c) << 1) - ONE_D;
    end
`endif
  end

  // Pipeline registers; all stages hold (bubbles included) while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sat    <= 1'b0;
      s1_t      <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_sat    <= 1'b0;
      s2_p      <= '0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
`ifdef SIGMOID_TANH_EN
      s1_mode   <= 1'b0;
      s2_mode   <= 1'b0;
`endif
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_sign   <= x_c[DATA_W-1];
      s1_sat    <= sat_c;
      s1_t      <= t_c;
      s1_tag    <= in_tag;
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_sat    <= s1_sat;
      s2_p      <= P_W'(s1_t) * P_W'(s1_t);
      s2_tag    <= s1_tag;
      out_valid <= s2_valid;
      out_data  <= res_c;
      out_tag   <= s2_tag;
`ifdef SIGMOID_TANH_EN
      s1_mode   <= in_mode;
      s2_mode   <= s1_mode;
`endif
    end
  end

endmodule
